// File: rtl/control_sequencer_if.sv
// control_sequencer_if -- bundle between the control sequencer and the datapath.
//   master : sequencer side; samples IR/mem_rdy/Stop, drives every control strobe,
//            alu_op and the debug step code.
//   slave  : datapath side; mirror image of master.
interface control_sequencer_if;
  logic [31:0] IR;       // instruction register, opcode in [31:27]
  logic        mem_rdy;  // current Read/Write completes this cycle
  logic        Stop;     // halt request, honoured only at T0

  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin;
  logic Zin, ZLOout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, Run;
  logic [3:0]  alu_op;   // 0 ADD, 1 SUB, 2 AND, 3 OR
  logic [3:0]  step;     // RST=0, T0..T7=1..8, HALT=15

  modport master (
    input  IR, mem_rdy, Stop,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin,
           Zin, ZLOout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, Run, alu_op, step
  );

  modport slave (
    output IR, mem_rdy, Stop,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin,
           Zin, ZLOout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, Run, alu_op, step
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer -- Moore control unit stepping fetch (T0..T2) and execute
// (T3..T7) for ld/st/add/sub/and/or/addi/halt; other opcodes are NOPs.
//   Clock : rising-edge system clock
//   Clear : asynchronous active-low reset, forces RST (all outputs 0)
//   bus   : control_sequencer_if.master (IR/mem_rdy/Stop in, controls out)
module control_sequencer (
  input  logic                   Clock,
  input  logic                   Clear,
  control_sequencer_if.master    bus
);

  // Encodings double as the debug step code.
  typedef enum logic [3:0] {
    RST = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
    T4  = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, HALT = 4'd15
  } state_t;

  typedef struct packed {
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin;
    logic Zin, ZLOout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, Run;
  } ctrl_t;

  localparam logic [4:0] OP_LD = 5'b00000, OP_ST = 5'b00010, OP_ADD = 5'b00011,
                         OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110,
                         OP_ADDI = 5'b01100, OP_HALT = 5'b11011;

  state_t     state, nxt;
  ctrl_t      c;
  logic [3:0] alu;

  logic [4:0] opc;
  logic       is_alu, is_addi, is_ld, is_st, is_ls, is_halt;
  logic [3:0] alu_sel;
  logic       unused_ir;

  assign opc       = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];
  assign is_alu    = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
  assign is_addi   = (opc == OP_ADDI);
  assign is_ld     = (opc == OP_LD);
  assign is_st     = (opc == OP_ST);
  assign is_ls     = is_ld || is_st;
  assign is_halt   = (opc == OP_HALT);

  always_comb begin
    case (opc)
      OP_SUB:  alu_sel = 4'd1;
      OP_AND:  alu_sel = 4'd2;
      OP_OR:   alu_sel = 4'd3;
      default: alu_sel = 4'd0;
    endcase
  end

  // State register
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state <= RST;
    else        state <= nxt;
  end

  // Next-state
  always_comb begin
    nxt = state;
    case (state)
      RST:  nxt = T0;
      T0:   nxt = bus.Stop ? HALT : T1;
      T1:   nxt = bus.mem_rdy ? T2 : T1;
      T2:   nxt = T3;
      T3:   if (is_alu || is_addi || is_ls) nxt = T4;
            else if (is_halt)               nxt = HALT;
            else                            nxt = T0;
      T4:   nxt = T5;
      T5:   nxt = is_ls ? T6 : T0;
      T6:   if (is_ld)      nxt = bus.mem_rdy ? T7 : T6;
            else if (is_st) nxt = T7;
            else            nxt = T0;
      T7:   if (is_st)      nxt = bus.mem_rdy ? T0 : T7;
            else            nxt = T0;
      HALT: nxt = HALT;
      default: nxt = RST;
    endcase
  end

  // Outputs: purely state + IR, so an asynchronous Clear silences them at once.
  always_comb begin
    c   = '0;
    alu = 4'd0;
    case (state)
      T0: begin c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; c.Zin = 1'b1; end
      T1: begin c.ZLOout = 1'b1; c.PCin = 1'b1; c.Read = 1'b1; c.MDRin = 1'b1; end
      T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
      T3: if (is_ls) begin
            c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1;
          end else if (is_alu || is_addi) begin
            c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1;
          end
      T4: if (is_alu) begin
            c.Grc = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; alu = alu_sel;
          end else if (is_addi || is_ls) begin
            c.Cout = 1'b1; c.Zin = 1'b1;   // alu stays ADD
          end
      T5: if (is_alu || is_addi) begin
            c.ZLOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
          end else if (is_ls) begin
            c.ZLOout = 1'b1; c.MARin = 1'b1;
          end
      T6: if (is_ld) begin
            c.Read = 1'b1; c.MDRin = 1'b1;
          end else if (is_st) begin
            c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1;
          end
      T7: if (is_ld) begin
            c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
          end else if (is_st) begin
            c.Write = 1'b1;
          end
      default: ;
    endcase
    c.Run = (state != RST) && (state != HALT);
  end

  assign bus.PCout  = c.PCout;   assign bus.PCin   = c.PCin;
  assign bus.IncPC  = c.IncPC;   assign bus.MARin  = c.MARin;
  assign bus.MDRin  = c.MDRin;   assign bus.MDRout = c.MDRout;
  assign bus.Read   = c.Read;    assign bus.Write  = c.Write;
  assign bus.IRin   = c.IRin;    assign bus.Yin    = c.Yin;
  assign bus.Zin    = c.Zin;     assign bus.ZLOout = c.ZLOout;
  assign bus.Cout   = c.Cout;    assign bus.Gra    = c.Gra;
  assign bus.Grb    = c.Grb;     assign bus.Grc    = c.Grc;
  assign bus.Rin    = c.Rin;     assign bus.Rout   = c.Rout;
  assign bus.BAout  = c.BAout;   assign bus.Run    = c.Run;
  assign bus.alu_op = alu;
  assign bus.step   = state;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic Clear = 1'b1;

  control_sequencer_if bus ();

  control_sequencer dut (.Clock(Clock), .Clear(Clear), .bus(bus));

  always #5 Clock = ~Clock;

  // Control vector bit positions (PCout = MSB ... Run = LSB)
  localparam logic [19:0] PCOUT = 20'h80000, PCIN = 20'h40000, INCPC = 20'h20000,
    MARIN = 20'h10000, MDRIN = 20'h08000, MDROUT = 20'h04000, READ = 20'h02000,
    WRITE = 20'h01000, IRIN = 20'h00800, YIN = 20'h00400, ZIN = 20'h00200,
    ZLO = 20'h00100, COUT = 20'h00080, GRA = 20'h00040, GRB = 20'h00020,
    GRC = 20'h00010, RIN = 20'h00008, ROUT = 20'h00004, BAOUT = 20'h00002,
    RUN = 20'h00001;

  localparam logic [3:0] S_RST = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd15;

  localparam logic [31:0] I_LD = 32'h0000_0000, I_ST = 32'h1000_0000, I_ADD = 32'h1800_0000,
    I_SUB = 32'h2000_0000, I_AND = 32'h2800_0000, I_OR = 32'h3000_0000,
    I_ADDI = 32'h6000_0000, I_HALT = 32'hD800_0000, I_NOP = 32'h0800_0000;

  typedef struct {
    string       tag;
    logic [27:0] val;   // {step, alu_op, controls}
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [27:0] observed();
    return {bus.step, bus.alu_op,
            bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
            bus.Read, bus.Write, bus.IRin, bus.Yin, bus.Zin, bus.ZLOout, bus.Cout,
            bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.Run};
  endfunction

  task automatic push(input string tag, input logic [3:0] st, input logic [3:0] alu,
                      input logic [19:0] ct);
    exp_t e;
    e.tag = tag;
    e.val = {st, alu, ct};
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t        e;
    logic [27:0] obs;
    obs = observed();
    e   = sb.pop_front();
    n_chk++;
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed step=%0d alu=%0d ctrl=%05h, expected step=%0d alu=%0d ctrl=%05h",
             e.tag, obs[27:24], obs[23:20], obs[19:0], e.val[27:24], e.val[23:20], e.val[19:0]);
    end
  endtask

  // Expect a step, then compare at the next falling edge (mid-cycle).
  task automatic step_chk(input string tag, input logic [3:0] st, input logic [3:0] alu,
                          input logic [19:0] ct);
    push(tag, st, alu, ct);
    @(negedge Clock);
    check_now();
  endtask

  // Fetch with mem_rdy=1; IR takes the new instruction during T1 (loaded at T2).
  task automatic fetch(input string tag, input logic [31:0] ir);
    step_chk({tag, "_t0"}, S_T0, 4'd0, RUN | PCOUT | MARIN | INCPC | ZIN);
    bus.IR = ir;
    step_chk({tag, "_t1"}, S_T1, 4'd0, RUN | ZLO | PCIN | READ | MDRIN);
    step_chk({tag, "_t2"}, S_T2, 4'd0, RUN | MDROUT | IRIN);
  endtask

  task automatic exec_alu(input string tag, input logic [3:0] alu, input bit addi);
    step_chk({tag, "_t3"}, S_T3, 4'd0, RUN | GRB | ROUT | YIN);
    if (addi) step_chk({tag, "_t4"}, S_T4, 4'd0, RUN | COUT | ZIN);
    else      step_chk({tag, "_t4"}, S_T4, alu,  RUN | GRC | ROUT | ZIN);
    step_chk({tag, "_t5"}, S_T5, 4'd0, RUN | ZLO | GRA | RIN);
  endtask

  task automatic exec_ls(input string tag);
    step_chk({tag, "_t3"}, S_T3, 4'd0, RUN | GRB | BAOUT | YIN);
    step_chk({tag, "_t4"}, S_T4, 4'd0, RUN | COUT | ZIN);
    step_chk({tag, "_t5"}, S_T5, 4'd0, RUN | ZLO | MARIN);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.IR = I_ADD; bus.mem_rdy = 1'b1; bus.Stop = 1'b0;

    // Reset
    #2 Clear = 1'b0;
    #1 push("reset_async", S_RST, 4'd0, 20'h0); check_now();
    step_chk("reset_hold0", S_RST, 4'd0, 20'h0);
    step_chk("reset_hold1", S_RST, 4'd0, 20'h0);
    Clear = 1'b1;

    // add, zero wait: steps 1..6 then 1
    fetch("add", I_ADD);
    exec_alu("add", 4'd0, 1'b0);

    // sub with three extra T1 cycles
    step_chk("sub_t0", S_T0, 4'd0, RUN | PCOUT | MARIN | INCPC | ZIN);
    bus.IR = I_SUB; bus.mem_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_chk("sub_t1_wait", S_T1, 4'd0, RUN | ZLO | PCIN | READ | MDRIN);
      if (i == 3) bus.mem_rdy = 1'b1;
    end
    step_chk("sub_t2", S_T2, 4'd0, RUN | MDROUT | IRIN);
    exec_alu("sub", 4'd1, 1'b0);

    // and: mem_rdy low during execute must not stall anything
    fetch("and", I_AND);
    bus.mem_rdy = 1'b0;
    exec_alu("and", 4'd2, 1'b0);
    bus.mem_rdy = 1'b1;

    fetch("or", I_OR);     exec_alu("or", 4'd3, 1'b0);
    fetch("addi", I_ADDI); exec_alu("addi", 4'd0, 1'b1);

    fetch("nop", I_NOP);
    step_chk("nop_t3", S_T3, 4'd0, RUN);

    // ld, zero wait; Stop outside T0 is ignored
    fetch("ld", I_LD);
    bus.Stop = 1'b1;
    exec_ls("ld");
    step_chk("ld_t6", S_T6, 4'd0, RUN | READ | MDRIN);
    step_chk("ld_t7", S_T7, 4'd0, RUN | MDROUT | GRA | RIN);
    bus.Stop = 1'b0;

    // st with two extra T7 cycles
    fetch("st", I_ST);
    exec_ls("st");
    step_chk("st_t6", S_T6, 4'd0, RUN | GRA | ROUT | MDRIN);
    bus.mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_chk("st_t7_wait", S_T7, 4'd0, RUN | WRITE);
      if (i == 2) bus.mem_rdy = 1'b1;
    end

    // Stop at T0 -> HALT, absorbing under input noise
    step_chk("stop_t0", S_T0, 4'd0, RUN | PCOUT | MARIN | INCPC | ZIN);
    bus.Stop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_chk("halt_absorb", S_HALT, 4'd0, 20'h0);
      bus.mem_rdy = 1'($urandom);
      bus.IR      = $urandom;
      bus.Stop    = 1'($urandom);
    end
    #2 Clear = 1'b0;
    #1 push("halt_clear_async", S_RST, 4'd0, 20'h0); check_now();
    step_chk("halt_clear_hold", S_RST, 4'd0, 20'h0);
    bus.mem_rdy = 1'b1; bus.Stop = 1'b0;
    Clear = 1'b1;

    // halt opcode
    fetch("hop", I_HALT);
    step_chk("hop_t3", S_T3, 4'd0, RUN);
    step_chk("hop_halt", S_HALT, 4'd0, 20'h0);
    step_chk("hop_halt2", S_HALT, 4'd0, 20'h0);
    #2 Clear = 1'b0;
    #1 push("hop_clear_async", S_RST, 4'd0, 20'h0); check_now();
    step_chk("hop_clear_hold", S_RST, 4'd0, 20'h0);
    Clear = 1'b1;

    // ld aborted by Clear during the T6 memory wait
    fetch("ldab", I_LD);
    exec_ls("ldab");
    bus.mem_rdy = 1'b0;
    step_chk("ldab_t6", S_T6, 4'd0, RUN | READ | MDRIN);
    step_chk("ldab_t6_wait", S_T6, 4'd0, RUN | READ | MDRIN);
    #2 Clear = 1'b0;
    #1 push("ldab_clear_async", S_RST, 4'd0, 20'h0); check_now();
    bus.mem_rdy = 1'b1;
    step_chk("ldab_rst0", S_RST, 4'd0, 20'h0);
    Clear = 1'b1;
    fetch("restart", I_ADD);
    exec_alu("restart", 4'd0, 1'b0);
    step_chk("restart_t0", S_T0, 4'd0, RUN | PCOUT | MARIN | INCPC | ZIN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
